// File: rtl/alien_pkg.sv
// alien_pkg
// Shared definitions for the alien march controller and the alien
// motion/collision block.
//   MOTION_* : 3-bit motion command codes driven on the formation's motion input.
//   march_state_t : march controller FSM states.
package alien_pkg;

    localparam logic [2:0] MOTION_NONE  = 3'd0;
    localparam logic [2:0] MOTION_LEFT  = 3'd1;
    localparam logic [2:0] MOTION_RIGHT = 3'd2;
    localparam logic [2:0] MOTION_DOWN  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MARCH_R = 3'd1,
        ST_MARCH_L = 3'd2,
        ST_DESCEND = 3'd3,
        ST_HALT    = 3'd4
    } march_state_t;

endpackage

// File: rtl/alien_step_timer.sv
// alien_step_timer
// This module paces the formation. It counts video frames down from the
// current step period and raises a step event on the frame that completes a
// period. When the optional speed-up is built in, it also shortens the period
// once for each alien that is killed.
// Build option: define ALIEN_SPEEDUP_EN to include the kill-driven speed-up.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_run          : counting allowed (enabled, marching, not halting)
//   i_frame_tick   : one-cycle pulse per video frame
//   i_kill         : collision flag, may stay high several cycles per kill
//   o_step         : combinational step-event pulse (tick with counter==1)
//   o_period       : current step period in frames
module alien_step_timer #(
    parameter int PERIOD_INIT = 30,
    parameter int PERIOD_MIN  = 2,
    parameter int PERIOD_DEC  = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_frame_tick,
    input  logic             i_kill,
    output logic             o_step,
    output logic [CNT_W-1:0] o_period
);

    logic [CNT_W-1:0] r_frame_cnt;
    logic             w_count;

    assign w_count = i_run && i_frame_tick;
    assign o_step  = w_count && (r_frame_cnt == CNT_W'(1));

    // The reload reads o_period before any same-cycle kill update lands, so a
    // kill that coincides with a step only affects the following reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= CNT_W'(PERIOD_INIT);
        end else if (w_count) begin
            if (o_step)
                r_frame_cnt <= o_period;
            else
                r_frame_cnt <= r_frame_cnt - CNT_W'(1);
        end
    end

`ifdef ALIEN_SPEEDUP_EN
    logic [CNT_W-1:0] r_period;
    logic             r_kill_d;
    logic             w_kill_rise;

    // The comparison runs before the subtraction so the period cannot wrap.
    function automatic logic [CNT_W-1:0] next_period(input logic [CNT_W-1:0] p);
        if (p <= CNT_W'(PERIOD_MIN + PERIOD_DEC))
            return CNT_W'(PERIOD_MIN);
        else
            return p - CNT_W'(PERIOD_DEC);
    endfunction

    assign w_kill_rise = i_kill && !r_kill_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kill_d <= 1'b0;
            r_period <= CNT_W'(PERIOD_INIT);
        end else begin
            r_kill_d <= i_kill;
            if (w_kill_rise)
                r_period <= next_period(r_period);
        end
    end

    assign o_period = r_period;
`else
    logic w_unused_kill;

    assign w_unused_kill = i_kill;
    assign o_period      = CNT_W'(PERIOD_INIT);
`endif

endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl
// This module generates the march command stream for the alien formation. The
// formation sweeps right and then left. At each edge it descends DOWN_STEPS
// rows. Each command is paced by alien_step_timer. Victory or defeat halts the
// formation until the next reset.
// Build option: define ALIEN_SPEEDUP_EN so that kills shorten the step period.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   enable                : level, 0 pauses marching (all state held)
//   frame_tick            : one-cycle pulse per video frame
//   can_left, can_right   : formation edge feedback, sampled on the tick
//   killing_alien         : collision flag (used only by speed-up builds)
//   victory, defeat       : game-over conditions
//   motion                : registered one-cycle motion command (alien_pkg codes)
//   dir_right             : current sweep direction
//   halted                : sticky game-over flag
//   period_cur            : current step period in frames
module alien_march_ctrl
    import alien_pkg::*;
#(
    parameter int PERIOD_INIT = 30,
    parameter int PERIOD_MIN  = 2,
    parameter int PERIOD_DEC  = 1,
    parameter int DOWN_STEPS  = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             can_left,
    input  logic             can_right,
    input  logic             killing_alien,
    input  logic             victory,
    input  logic             defeat,
    output logic [2:0]       motion,
    output logic             dir_right,
    output logic             halted,
    output logic [CNT_W-1:0] period_cur
);

    localparam int DC_W = $clog2(DOWN_STEPS + 1);

    march_state_t    r_state, w_state_nxt;
    logic [DC_W-1:0] r_down_cnt, w_down_cnt_nxt;
    logic            r_dir_right, w_dir_right_nxt;
    logic [2:0]      r_motion, w_motion_nxt;
    logic            w_game_over;
    logic            w_marching;
    logic            w_run;
    logic            w_step;

    assign w_game_over = victory || defeat;
    assign w_marching  = (r_state == ST_MARCH_R) || (r_state == ST_MARCH_L) ||
                         (r_state == ST_DESCEND);
    // Game over freezes the counter in the same cycle that HALT is taken.
    assign w_run       = enable && w_marching && !w_game_over;

    alien_step_timer #(
        .PERIOD_INIT (PERIOD_INIT),
        .PERIOD_MIN  (PERIOD_MIN),
        .PERIOD_DEC  (PERIOD_DEC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_run        (w_run),
        .i_frame_tick (frame_tick),
        .i_kill       (killing_alien),
        .o_step       (w_step),
        .o_period     (period_cur)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_down_cnt  <= '0;
            r_dir_right <= 1'b1;
            r_motion    <= MOTION_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_down_cnt  <= w_down_cnt_nxt;
            r_dir_right <= w_dir_right_nxt;
            r_motion    <= w_motion_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_down_cnt_nxt  = r_down_cnt;
        w_dir_right_nxt = r_dir_right;
        w_motion_nxt    = MOTION_NONE;

        if (w_game_over) begin
            w_state_nxt = ST_HALT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable)
                        w_state_nxt = ST_MARCH_R;
                end
                ST_MARCH_R: begin
                    if (w_step) begin
                        if (can_right) begin
                            w_motion_nxt = MOTION_RIGHT;
                        end else begin
                            w_motion_nxt    = MOTION_DOWN;
                            w_dir_right_nxt = 1'b0;
                            w_down_cnt_nxt  = DC_W'(DOWN_STEPS - 1);
                            w_state_nxt     = (DOWN_STEPS == 1) ? ST_MARCH_L : ST_DESCEND;
                        end
                    end
                end
                ST_MARCH_L: begin
                    if (w_step) begin
                        if (can_left) begin
                            w_motion_nxt = MOTION_LEFT;
                        end else begin
                            w_motion_nxt    = MOTION_DOWN;
                            w_dir_right_nxt = 1'b1;
                            w_down_cnt_nxt  = DC_W'(DOWN_STEPS - 1);
                            w_state_nxt     = (DOWN_STEPS == 1) ? ST_MARCH_R : ST_DESCEND;
                        end
                    end
                end
                ST_DESCEND: begin
                    if (w_step) begin
                        w_motion_nxt   = MOTION_DOWN;
                        w_down_cnt_nxt = r_down_cnt - DC_W'(1);
                        if (r_down_cnt == DC_W'(1))
                            w_state_nxt = r_dir_right ? ST_MARCH_R : ST_MARCH_L;
                    end
                end
                ST_HALT: begin
                    w_state_nxt = ST_HALT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign motion    = r_motion;
    assign dir_right = r_dir_right;
    assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_alien_march_ctrl.sv
module tb_alien_march_ctrl;

    localparam int CNT_W = 8;
`ifdef ALIEN_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    localparam int M_NONE  = 0;
    localparam int M_LEFT  = 1;
    localparam int M_RIGHT = 2;
    localparam int M_DOWN  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             frame_tick = 1'b0;
    logic             can_left = 1'b0;
    logic             can_right = 1'b0;
    logic             killing_alien = 1'b0;
    logic             victory = 1'b0;
    logic             defeat = 1'b0;
    logic [2:0]       motion;
    logic             dir_right;
    logic             halted;
    logic [CNT_W-1:0] period_cur;

    int checks = 0;
    int errors = 0;

    alien_march_ctrl #(
        .PERIOD_INIT (4),
        .PERIOD_MIN  (2),
        .PERIOD_DEC  (1),
        .DOWN_STEPS  (3),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .frame_tick    (frame_tick),
        .can_left      (can_left),
        .can_right     (can_right),
        .killing_alien (killing_alien),
        .victory       (victory),
        .defeat        (defeat),
        .motion        (motion),
        .dir_right     (dir_right),
        .halted        (halted),
        .period_cur    (period_cur)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // One frame tick, then check the motion pulse and the idle cycle after it.
    task automatic tick_expect(input string tag, input int exp);
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        check(tag, 32'(motion), exp);
        cycle();
        check({tag, "_gap"}, 32'(motion), M_NONE);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_motion"}, 32'(motion), M_NONE);
        check({tag, "_dir"}, 32'(dir_right), 1);
        check({tag, "_halted"}, 32'(halted), 0);
        check({tag, "_period"}, 32'(period_cur), 4);
    endtask

    initial begin
        // Reset values and a rightward march: RIGHT on ticks 4 and 8.
        do_reset();
        check_reset_outputs("rst");
        enable = 1'b1;
        can_right = 1'b1;
        cycle();
        for (int i = 1; i <= 8; i++)
            tick_expect($sformatf("right_t%0d", i), (i % 4 == 0) ? M_RIGHT : M_NONE);

        // Right edge: DOWN on ticks 4, 8 and 12, then LEFT on tick 16.
        do_reset();
        enable = 1'b1;
        can_right = 1'b1;
        can_left = 1'b0;
        cycle();
        for (int i = 1; i <= 16; i++) begin
            if (i == 4) can_right = 1'b0;
            if (i == 13) can_left = 1'b1;
            if (i == 4 || i == 8 || i == 12)
                tick_expect($sformatf("edge_t%0d", i), M_DOWN);
            else if (i == 16)
                tick_expect($sformatf("edge_t%0d", i), M_LEFT);
            else
                tick_expect($sformatf("edge_t%0d", i), M_NONE);
            if (i == 4) check("edge_dir_after_t4", 32'(dir_right), 0);
        end
        check("edge_dir_final", 32'(dir_right), 0);

        // A pause: ticks while disabled are ignored and the count resumes.
        do_reset();
        enable = 1'b1;
        can_right = 1'b1;
        cycle();
        tick_expect("pause_t1", M_NONE);
        tick_expect("pause_t2", M_NONE);
        enable = 1'b0;
        for (int i = 0; i < 5; i++)
            tick_expect($sformatf("pause_off%0d", i), M_NONE);
        enable = 1'b1;
        tick_expect("pause_t3", M_NONE);
        tick_expect("pause_t4", M_RIGHT);

        // Kills, each held high for 3 cycles: the period goes 4 -> 3 -> 2 -> 2.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            killing_alien = 1'b1;
            repeat (3) cycle();
            killing_alien = 1'b0;
            repeat (2) cycle();
            check($sformatf("kill%0d_period", k), 32'(period_cur),
                  SPEEDUP ? ((k == 1) ? 3 : 2) : 4);
        end

        // Defeat on a step tick: no motion, halted, nothing more until reset.
        do_reset();
        enable = 1'b1;
        can_right = 1'b1;
        cycle();
        for (int i = 1; i <= 3; i++)
            tick_expect($sformatf("defeat_t%0d", i), M_NONE);
        defeat = 1'b1;
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        defeat = 1'b0;
        check("defeat_motion", 32'(motion), M_NONE);
        check("defeat_halted", 32'(halted), 1);
        for (int i = 1; i <= 5; i++)
            tick_expect($sformatf("halt_t%0d", i), M_NONE);
        check("halt_sticky", 32'(halted), 1);

        // Reset in the middle of a descent, then a fresh march starts RIGHT.
        do_reset();
        check("postdefeat_rst_halted", 32'(halted), 0);
        enable = 1'b1;
        can_right = 1'b0;
        cycle();
        for (int i = 1; i <= 5; i++)
            tick_expect($sformatf("desc_t%0d", i), (i == 4) ? M_DOWN : M_NONE);
        check("desc_dir", 32'(dir_right), 0);
        do_reset();
        check_reset_outputs("midrst");
        can_right = 1'b1;
        cycle();
        for (int i = 1; i <= 4; i++)
            tick_expect($sformatf("restart_t%0d", i), (i == 4) ? M_RIGHT : M_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alien_march_ctrl.md
# alien_march_ctrl

Generates the march command stream for the alien formation. Each alien step is paced by a frame-tick counter. The block sweeps the formation right and left, and descends at each edge using the formation's `can_left`/`can_right` feedback. It optionally speeds up as aliens are killed. It sits between the VGA frame timing and the alien motion/collision block, and drives that block's 3-bit `motion` input.

## Interface
- `PERIOD_INIT`, 30: frames between steps after reset.
- `PERIOD_MIN`, 2: floor for the step period (≥1).
- `PERIOD_DEC`, 1: period reduction per kill (speed-up builds only).
- `DOWN_STEPS`, 15: DOWN commands issued per edge turn (≥1).
- `CNT_W`, 8: width of period and frame counters.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: level; 0 pauses marching.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `can_left` in 1: formation may step left.
- `can_right` in 1: formation may step right.
- `killing_alien` in 1: collision flag from formation; may stay high several cycles per kill.
- `victory` in 1: all aliens dead.
- `defeat` in 1: formation reached bottom limit.
- `motion` out 3: 0 NONE, 1 LEFT, 2 RIGHT, 3 DOWN; single-cycle pulse.
- `dir_right` out 1: current sweep direction.
- `halted` out 1: game over, sticky.
- `period_cur` out CNT_W: current step period in frames.

## Operation
- States:
  - IDLE: after reset.
  - MARCH_R, MARCH_L: sweeping.
  - DESCEND: mid-turn.
  - HALT: game over.
- IDLE → MARCH_R when `enable`=1.
- Frame counter:
  - Loaded with `period_cur` at reset and on each step.
  - Decrements on `frame_tick` while `enable`=1 and state ∈ {MARCH_R, MARCH_L, DESCEND}.
  - A tick seen with counter==1 is a step event; the counter reloads to `period_cur`.
- MARCH_R step:
  - `can_right`=1: `motion`=RIGHT.
  - Otherwise: `motion`=DOWN, `dir_right`←0, `down_cnt`←DOWN_STEPS-1, next state DESCEND. If DOWN_STEPS=1, next state is MARCH_L directly.
- MARCH_L: mirror of MARCH_R using `can_left`/LEFT; sets `dir_right`←1.
- DESCEND step:
  - `motion`=DOWN, `down_cnt` decrements.
  - When `down_cnt`==1 before the step, next state is MARCH_R if `dir_right`, else MARCH_L.
- Kill detection: rising edge of `killing_alien` (registered copy) counts exactly one kill.
- HALT:
  - Entered from any state when `victory` or `defeat` is 1, in the cycle it is sampled.
  - `motion`=0, `halted`=1, counter frozen.
  - Exits only on reset.
- `enable`=0 mid-march: state, counters and `down_cnt` are held; no motion issued; resumes unchanged.

## Timing
- Reset values: `motion`=0, `dir_right`=1, `halted`=0, `period_cur`=PERIOD_INIT, frame counter=PERIOD_INIT, state IDLE, `down_cnt`=0.
- `motion` is registered. It is nonzero for exactly one cycle: the cycle after the `frame_tick` that produced the step event.
- `can_left`/`can_right` are sampled in the `frame_tick` cycle.
- Kill arriving in the same cycle as a step event: the new `period_cur` takes effect at the next reload; the current reload uses the old value.
- `victory`/`defeat` in the same cycle as a step event: HALT wins; no motion is issued.
- `frame_tick` while `enable`=0: ignored, not queued.
- Arithmetic is unsigned.
- `period_cur` update: if `period_cur` − PERIOD_DEC < PERIOD_MIN, `period_cur`←PERIOD_MIN. The comparison is done without underflow (check `period_cur` ≤ PERIOD_MIN+PERIOD_DEC first).

## Configuration
- `ALIEN_SPEEDUP_EN` defined: each detected kill reduces `period_cur` by PERIOD_DEC, clamped at PERIOD_MIN.
- Not defined: `period_cur` is constant PERIOD_INIT; `killing_alien` is ignored and the edge-detect register is not instantiated.

## Structure
- Shared package `alien_pkg`:
  - Motion codes MOTION_NONE/LEFT/RIGHT/DOWN = 0/1/2/3, also used by the motion/collision block.
  - State enum for this FSM.
- Sub-module `alien_step_timer`: frame counter, reload, step-event pulse, period register and kill-driven speed-up. The top holds the FSM, `down_cnt` and output registers.

## Test plan
All scenarios use PERIOD_INIT=4, DOWN_STEPS=3, PERIOD_MIN=2, PERIOD_DEC=1.
- Reset, `enable`=1, `can_right`=1, 8 ticks → RIGHT pulses one cycle after ticks 4 and 8; `motion`=0 elsewhere.
- `can_right`=0 at tick 4 → DOWN after ticks 4, 8, 12; `dir_right`=0 after tick 4; LEFT after tick 16 with `can_left`=1.
- `enable` dropped after tick 2 for 5 ticks, then raised → next RIGHT after 2 further ticks.
- `killing_alien` held high 3 cycles, three separate times (speed-up build) → `period_cur` 4→3→2→2; no change in a non-speed-up build.
- `defeat` asserted in the same cycle as a step-producing tick → `motion` stays 0, `halted`=1, no further commands until reset.
- Reset mid-DESCEND → all outputs at reset values next cycle; first command after `enable` is RIGHT.
